// File: rtl/counter_pkg.sv
// Shared mode and direction encodings for the up/down/bounce counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_next_logic.sv
// Combinational next-count, next-direction and boundary-event logic for one enabled step.
module counter_next_logic
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             sat,
  output logic [WIDTH-1:0] nxt_count,
  output logic             nxt_dir,
  output logic             step_evt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic at_max;
  logic at_min;

  assign at_max = (count == MAXV);
  assign at_min = (count == '0);

  always_comb begin
    nxt_count = count;
    nxt_dir   = dir;
    step_evt  = 1'b0;
    wrap      = 1'b0;
    case (mode)
      MODE_UP: begin
        nxt_dir = DIR_UP;
        if (!at_max) begin
          nxt_count = count + ONE;
        end else begin
          step_evt = 1'b1;
          if (!sat) begin
            nxt_count = '0;
            wrap      = 1'b1;
          end
        end
      end
      MODE_DOWN: begin
        nxt_dir = DIR_DOWN;
        if (!at_min) begin
          nxt_count = count - ONE;
        end else begin
          step_evt = 1'b1;
          if (!sat) begin
            nxt_count = MAXV;
            wrap      = 1'b1;
          end
        end
      end
      MODE_BOUNCE: begin
        // dir doubles as the bounce FSM state, so entering BOUNCE needs no setup cycle
        if (dir == DIR_UP) begin
          if (!at_max) begin
            nxt_count = count + ONE;
          end else begin
            nxt_count = MAXV - ONE;
            nxt_dir   = DIR_DOWN;
            step_evt  = 1'b1;
          end
        end else begin
          if (!at_min) begin
            nxt_count = count - ONE;
          end else begin
            nxt_count = ONE;
            nxt_dir   = DIR_UP;
            step_evt  = 1'b1;
          end
        end
      end
      default: begin
        nxt_count = count;
        nxt_dir   = dir;
      end
    endcase
  end

endmodule

// File: rtl/updown_counter_n.sv
// Registered up/down/bounce counter with load, saturate-or-wrap and sticky wrap flag.
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             evt,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV = MAX[WIDTH-1:0];

  logic [WIDTH-1:0] nxt_count;
  logic             nxt_dir;
  logic             step_evt;
  logic             wrap;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  counter_next_logic #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_next (
    .count     (count),
    .dir       (dir),
    .mode      (mode),
    .sat       (sat),
    .nxt_count (nxt_count),
    .nxt_dir   (nxt_dir),
    .step_evt  (step_evt),
    .wrap      (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      dir   <= DIR_UP;
      evt   <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= clamp_load(load_val);
      evt   <= 1'b0;
      ovf   <= 1'b0;
    end else if (en) begin
      count <= nxt_count;
      dir   <= nxt_dir;
      evt   <= step_evt;
      if (wrap) ovf <= 1'b1;
    end else begin
      evt   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed and randomized checks of updown_counter_n (WIDTH=4, MAX=9) against an integer model.
module tb_updown_counter_n;

  localparam int W = 4;
  localparam int M = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [1:0]   mode = 2'b00;
  logic         sat = 1'b0;
  logic [W-1:0] count;
  logic         dir;
  logic         evt;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  // reference state held as plain integers
  int mc = 0;
  int md = 0;
  int me = 0;
  int mo = 0;

  updown_counter_n #(.WIDTH(W), .MAX(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .sat      (sat),
    .count    (count),
    .dir      (dir),
    .evt      (evt),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic model_step(input int r, input int ld, input int lv, input int e,
                            input int m, input int s);
    if (r != 0) begin
      mc = 0; md = 0; me = 0; mo = 0;
    end else if (ld != 0) begin
      mc = (lv > M) ? M : lv;
      mo = 0; me = 0;
    end else if (e == 0 || m == 3) begin
      me = 0;
    end else if (m == 0) begin
      md = 0;
      if (mc < M) begin mc = mc + 1; me = 0; end
      else begin me = 1; if (s == 0) begin mc = 0; mo = 1; end end
    end else if (m == 1) begin
      md = 1;
      if (mc > 0) begin mc = mc - 1; me = 0; end
      else begin me = 1; if (s == 0) begin mc = M; mo = 1; end end
    end else begin
      if (md == 0) begin
        if (mc < M) begin mc = mc + 1; me = 0; end
        else begin mc = M - 1; md = 1; me = 1; end
      end else begin
        if (mc > 0) begin mc = mc - 1; me = 0; end
        else begin mc = 1; md = 0; me = 1; end
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int r, input int ld, input int lv, input int e,
                      input int m, input int s);
    rst      = (r != 0);
    load     = (ld != 0);
    load_val = lv[W-1:0];
    en       = (e != 0);
    mode     = m[1:0];
    sat      = (s != 0);
    model_step(r, ld, lv, e, m, s);
    @(posedge clk);
    #1;
    check("count", int'(count), mc);
    check("dir",   int'(dir),   md);
    check("evt",   int'(evt),   me);
    check("ovf",   int'(ovf),   mo);
    check("count_le_max", int'(count <= M), 1);
  endtask

  initial begin
    @(negedge clk);

    // reset state
    step(1, 0, 0, 0, 0, 0);
    check("reset_count", int'(count), 0);

    // UP wrap: 1..9,0,1,2
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0, 0);
    check("up_final", int'(count), 2);
    check("up_ovf_sticky", int'(ovf), 1);

    // DOWN saturating from 2
    step(0, 1, 2, 0, 0, 0);
    check("load_clears_ovf", int'(ovf), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);
    check("down_sat_hold", int'(count), 0);

    // BOUNCE from 8 heading up (reset clears dir first)
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 8, 1, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 1, 2, 0);
    check("bounce_end", int'(count), 1);
    check("bounce_dir", int'(dir), 0);

    // hold variants
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0);

    // load clamps above MAX, load beats en; rst beats load
    step(0, 1, 14, 1, 0, 0);
    check("load_clamp", int'(count), 9);
    step(1, 1, 5, 1, 0, 0);
    check("rst_over_load", int'(count), 0);

    // rst mid-BOUNCE at count=5 heading down, then en=0 holds
    step(0, 1, 9, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 1, 2, 0);
    check("pre_rst_count", int'(count), 5);
    check("pre_rst_dir", int'(dir), 1);
    step(1, 0, 0, 1, 2, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2, 0);
    check("post_rst_hold", int'(count), 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r, ld, e;
      r  = ($urandom_range(0, 49) == 0) ? 1 : 0;
      ld = ($urandom_range(0, 19) == 0) ? 1 : 0;
      e  = ($urandom_range(0, 9) < 8) ? 1 : 0;
      step(r, ld, int'($urandom_range(0, 15)), e,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
